// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALUOp and forwarding encodings plus the control bundle types
// for the pipelined control unit. Optional forwarding is enabled by defining
// PIPE_CTRL_FWD_EN.
package pipe_ctrl_pkg;

    localparam int unsigned CTRL_OP_W   = 7;
    localparam int unsigned ALUOP_BITS  = 2;
    localparam int unsigned FWD_W       = 2;

    localparam logic [CTRL_OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [CTRL_OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [CTRL_OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [CTRL_OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [CTRL_OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUOP_BITS-1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [ALUOP_BITS-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_BITS-1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [ALUOP_BITS-1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

    // Full decoded bundle in ID
    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic [ALUOP_BITS-1:0] alu_op;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
    } ctrl_t;

    // Bundle still needed from EX onwards (branch is consumed in ID)
    typedef struct packed {
        logic                  mem_read;
        logic                  mem_to_reg;
        logic [ALUOP_BITS-1:0] alu_op;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    // MEM result is younger than WB, so it takes priority
    function automatic logic [FWD_W-1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_MEM;
        if (wb_hit)  return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode decoder: control bundle plus source-operand usage.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 7
) (
    input  logic [OP_W-1:0] i_op,
    output ctrl_t           o_ctrl_c,
    output logic            o_uses_rs1_c,
    output logic            o_uses_rs2_c
);

    // Opcode to control; unlisted opcodes decode as NOP
    always_comb begin
        o_ctrl_c     = '0;
        o_uses_rs1_c = 1'b0;
        o_uses_rs2_c = 1'b0;
        case (i_op)
            OP_W'(OP_RTYPE): begin
                o_ctrl_c.reg_write = 1'b1;
                o_ctrl_c.alu_op    = ALUOP_RTYPE;
                o_uses_rs1_c       = 1'b1;
                o_uses_rs2_c       = 1'b1;
            end
            OP_W'(OP_ITYPE): begin
                o_ctrl_c.reg_write = 1'b1;
                o_ctrl_c.alu_src   = 1'b1;
                o_ctrl_c.alu_op    = ALUOP_ITYPE;
                o_uses_rs1_c       = 1'b1;
            end
            OP_W'(OP_LOAD): begin
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.alu_src    = 1'b1;
                o_ctrl_c.mem_read   = 1'b1;
                o_ctrl_c.mem_to_reg = 1'b1;
                o_ctrl_c.alu_op     = ALUOP_ADDR;
                o_uses_rs1_c        = 1'b1;
            end
            OP_W'(OP_STORE): begin
                o_ctrl_c.alu_src   = 1'b1;
                o_ctrl_c.mem_write = 1'b1;
                o_ctrl_c.alu_op    = ALUOP_ADDR;
                o_uses_rs1_c       = 1'b1;
                o_uses_rs2_c       = 1'b1;
            end
            OP_W'(OP_BRANCH): begin
                o_ctrl_c.branch = 1'b1;
                o_ctrl_c.alu_op = ALUOP_BRANCH;
                o_uses_rs1_c    = 1'b1;
                o_uses_rs2_c    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / RAW stall, branch flush and optional operand forwarding
// (define PIPE_CTRL_FWD_EN to compile forwarding in).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 7,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned ALUOP_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic [RA_W-1:0]    rs1_i,
    input  logic [RA_W-1:0]    rs2_i,
    input  logic [RA_W-1:0]    rd_i,
    input  logic               branch_taken_i,
    output logic [ALUOP_W-1:0] ex_ALUOp_o,
    output logic               ex_ALUSrc_o,
    output logic               mem_MemRead_o,
    output logic               mem_MemWrite_o,
    output logic               wb_MemtoReg_o,
    output logic               wb_RegWrite_o,
    output logic [RA_W-1:0]    ex_rd_o,
    output logic [RA_W-1:0]    mem_rd_o,
    output logic [RA_W-1:0]    wb_rd_o,
    output logic               stall_o,
    output logic               flush_o,
    output logic [1:0]         fwd_a_o,
    output logic [1:0]         fwd_b_o
);

    ctrl_t           w_dec;
    ex_ctrl_t        w_dec_ex;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_rs1_ex_hit;
    logic            w_rs2_ex_hit;
    logic            w_hazard;
    logic            w_bubble;

    ex_ctrl_t        r_ex_ctrl;
    mem_ctrl_t       r_mem_ctrl;
    wb_ctrl_t        r_wb_ctrl;
    logic [RA_W-1:0] r_ex_rd;
    logic [RA_W-1:0] r_mem_rd;
    logic [RA_W-1:0] r_wb_rd;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .i_op         (Op_i),
        .o_ctrl_c     (w_dec),
        .o_uses_rs1_c (w_uses_rs1),
        .o_uses_rs2_c (w_uses_rs2)
    );

    assign w_dec_ex = '{mem_read:   w_dec.mem_read,
                        mem_to_reg: w_dec.mem_to_reg,
                        alu_op:     w_dec.alu_op,
                        mem_write:  w_dec.mem_write,
                        alu_src:    w_dec.alu_src,
                        reg_write:  w_dec.reg_write};

    // Used ID source registers colliding with the EX destination (x0 excluded)
    assign w_rs1_ex_hit = w_uses_rs1 && (r_ex_rd != '0) && (rs1_i == r_ex_rd);
    assign w_rs2_ex_hit = w_uses_rs2 && (r_ex_rd != '0) && (rs2_i == r_ex_rd);

`ifdef PIPE_CTRL_FWD_EN
    logic [RA_W-1:0] r_ex_rs1;
    logic [RA_W-1:0] r_ex_rs2;
    logic            w_fwd_a_mem;
    logic            w_fwd_a_wb;
    logic            w_fwd_b_mem;
    logic            w_fwd_b_wb;

    // Only a load in EX cannot be covered by forwarding
    assign w_hazard = r_ex_ctrl.mem_read && (w_rs1_ex_hit || w_rs2_ex_hit);

    assign w_fwd_a_mem = r_mem_ctrl.reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs1);
    assign w_fwd_a_wb  = r_wb_ctrl.reg_write  && (r_wb_rd  != '0) && (r_wb_rd  == r_ex_rs1);
    assign w_fwd_b_mem = r_mem_ctrl.reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs2);
    assign w_fwd_b_wb  = r_wb_ctrl.reg_write  && (r_wb_rd  != '0) && (r_wb_rd  == r_ex_rs2);

    assign fwd_a_o = rst_i ? FWD_NONE : fwd_select(w_fwd_a_mem, w_fwd_a_wb);
    assign fwd_b_o = rst_i ? FWD_NONE : fwd_select(w_fwd_b_mem, w_fwd_b_wb);

    // ID/EX copies of the source fields for the forwarding compare
    always_ff @(posedge clk_i) begin
        if (rst_i || w_bubble) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else begin
            r_ex_rs1 <= rs1_i;
            r_ex_rs2 <= rs2_i;
        end
    end
`else
    logic w_rs1_mem_hit;
    logic w_rs2_mem_hit;

    // Without forwarding any in-flight EX/MEM writer of a used source stalls;
    // WB is covered by the write-first register file
    assign w_rs1_mem_hit = w_uses_rs1 && (r_mem_rd != '0) && (rs1_i == r_mem_rd);
    assign w_rs2_mem_hit = w_uses_rs2 && (r_mem_rd != '0) && (rs2_i == r_mem_rd);
    assign w_hazard = (r_ex_ctrl.reg_write  && (w_rs1_ex_hit  || w_rs2_ex_hit)) ||
                      (r_mem_ctrl.reg_write && (w_rs1_mem_hit || w_rs2_mem_hit));

    assign fwd_a_o = FWD_NONE;
    assign fwd_b_o = FWD_NONE;
`endif

    assign stall_o  = ~rst_i & w_hazard;
    assign flush_o  = ~rst_i & w_dec.branch & branch_taken_i & valid_i & ~w_hazard;
    assign w_bubble = w_hazard | ~valid_i;

    // ID/EX: take the decoded bundle, or a bubble on stall / empty IF/ID
    always_ff @(posedge clk_i) begin
        if (rst_i || w_bubble) begin
            r_ex_ctrl <= '0;
            r_ex_rd   <= '0;
        end else begin
            r_ex_ctrl <= w_dec_ex;
            r_ex_rd   <= rd_i;
        end
    end

    // EX/MEM and MEM/WB: plain shift of the remaining controls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_ctrl <= '0;
            r_mem_rd   <= '0;
            r_wb_ctrl  <= '0;
            r_wb_rd    <= '0;
        end else begin
            r_mem_ctrl <= '{mem_read:   r_ex_ctrl.mem_read,
                            mem_to_reg: r_ex_ctrl.mem_to_reg,
                            mem_write:  r_ex_ctrl.mem_write,
                            reg_write:  r_ex_ctrl.reg_write};
            r_mem_rd   <= r_ex_rd;
            r_wb_ctrl  <= '{mem_to_reg: r_mem_ctrl.mem_to_reg,
                            reg_write:  r_mem_ctrl.reg_write};
            r_wb_rd    <= r_mem_rd;
        end
    end

    assign ex_ALUOp_o     = ALUOP_W'(r_ex_ctrl.alu_op);
    assign ex_ALUSrc_o    = r_ex_ctrl.alu_src;
    assign mem_MemRead_o  = r_mem_ctrl.mem_read;
    assign mem_MemWrite_o = r_mem_ctrl.mem_write;
    assign wb_MemtoReg_o  = r_wb_ctrl.mem_to_reg;
    assign wb_RegWrite_o  = r_wb_ctrl.reg_write;
    assign ex_rd_o        = r_ex_rd;
    assign mem_rd_o       = r_mem_rd;
    assign wb_rd_o        = r_wb_rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a reference model predicts the
// same-cycle hazard outputs and the next-edge pipeline contents; predicted
// register contents go through a scoreboard queue and are popped after the edge.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] T_R  = 7'b0110011;
    localparam logic [6:0] T_I  = 7'b0010011;
    localparam logic [6:0] T_LD = 7'b0000011;
    localparam logic [6:0] T_ST = 7'b0100011;
    localparam logic [6:0] T_BR = 7'b1100011;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_ON         = 1'b1;
    localparam int EXP_LU_STALLS  = 1;
    localparam int EXP_RAW_STALLS = 0;
    localparam int EXP_FWD_MEM    = 1;
    localparam int EXP_FWD_WB     = 1;
`else
    localparam bit FWD_ON         = 1'b0;
    localparam int EXP_LU_STALLS  = 2;
    localparam int EXP_RAW_STALLS = 3;
    localparam int EXP_FWD_MEM    = 0;
    localparam int EXP_FWD_WB     = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i, valid_i, branch_taken_i;
    logic [6:0] Op_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic [1:0] ex_ALUOp_o, fwd_a_o, fwd_b_o;
    logic       ex_ALUSrc_o, mem_MemRead_o, mem_MemWrite_o, wb_MemtoReg_o, wb_RegWrite_o;
    logic [4:0] ex_rd_o, mem_rd_o, wb_rd_o;
    logic       stall_o, flush_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .branch_taken_i(branch_taken_i),
        .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
        .wb_MemtoReg_o(wb_MemtoReg_o), .wb_RegWrite_o(wb_RegWrite_o),
        .ex_rd_o(ex_rd_o), .mem_rd_o(mem_rd_o), .wb_rd_o(wb_rd_o),
        .stall_o(stall_o), .flush_o(flush_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic br, mr, m2r;
        logic [1:0] aop;
        logic mw, as, rw, u1, u2;
    } m_dec_t;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       bt;
    } instr_t;

    function automatic m_dec_t m_decode(input logic [6:0] op);
        m_dec_t d = '0;
        case (op)
            T_R:  begin d.rw = 1; d.aop = 2'b10; d.u1 = 1; d.u2 = 1; end
            T_I:  begin d.rw = 1; d.as = 1; d.aop = 2'b11; d.u1 = 1; end
            T_LD: begin d.rw = 1; d.as = 1; d.mr = 1; d.m2r = 1; d.aop = 2'b00; d.u1 = 1; end
            T_ST: begin d.as = 1; d.mw = 1; d.aop = 2'b00; d.u1 = 1; d.u2 = 1; end
            T_BR: begin d.br = 1; d.aop = 2'b01; d.u1 = 1; d.u2 = 1; end
            default: ;
        endcase
        return d;
    endfunction

    // Reference pipeline state
    m_dec_t     m_ex, m_mem, m_wb;
    logic [4:0] m_ex_rd, m_ex_rs1, m_ex_rs2, m_mem_rd, m_wb_rd;

    logic [31:0] sb_q[$];
    instr_t      prog[$];
    int          obs_fwd_mem, obs_fwd_wb;

    function automatic instr_t mk(input logic [6:0] op, input int rd, input int rs1,
                                  input int rs2, input bit bt = 1'b0);
        instr_t t;
        t.rst = 1'b0; t.vld = 1'b1; t.op = op; t.bt = bt;
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        return t;
    endfunction

    task automatic add_nops(input int n);
        for (int i = 0; i < n; i++) prog.push_back(mk(7'd0, 0, 0, 0));
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (m_mem.rw && m_mem_rd != 0 && m_mem_rd == rs) return 2'b10;
        if (m_wb.rw && m_wb_rd != 0 && m_wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: drive at negedge, check combinational outputs, predict and
    // check the registered outputs after the rising edge
    task automatic do_cycle(input instr_t in, output logic st, output logic fl);
        m_dec_t      d;
        logic        h1, h2, m1, m2, haz;
        logic [1:0]  efa, efb;
        logic [31:0] exp_regs;
        rst_i = in.rst; valid_i = in.vld; Op_i = in.op;
        rs1_i = in.rs1; rs2_i = in.rs2; rd_i = in.rd; branch_taken_i = in.bt;
        d  = m_decode(in.op);
        h1 = d.u1 && m_ex_rd != 0 && in.rs1 == m_ex_rd;
        h2 = d.u2 && m_ex_rd != 0 && in.rs2 == m_ex_rd;
        m1 = d.u1 && m_mem_rd != 0 && in.rs1 == m_mem_rd;
        m2 = d.u2 && m_mem_rd != 0 && in.rs2 == m_mem_rd;
        if (FWD_ON) haz = m_ex.mr && (h1 || h2);
        else        haz = (m_ex.rw && (h1 || h2)) || (m_mem.rw && (m1 || m2));
        st  = !in.rst && haz;
        fl  = !in.rst && d.br && in.bt && in.vld && !st;
        efa = (FWD_ON && !in.rst) ? m_fwd(m_ex_rs1) : 2'b00;
        efb = (FWD_ON && !in.rst) ? m_fwd(m_ex_rs2) : 2'b00;
        #1;
        check_val("stall", 32'(stall_o), 32'(st));
        check_val("flush", 32'(flush_o), 32'(fl));
        check_val("fwd_ab", 32'({fwd_a_o, fwd_b_o}), 32'({efa, efb}));
        if (fwd_a_o == 2'b10) obs_fwd_mem++;
        if (fwd_a_o == 2'b01) obs_fwd_wb++;
        if (in.rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_ex_rd = 0; m_ex_rs1 = 0; m_ex_rs2 = 0; m_mem_rd = 0; m_wb_rd = 0;
        end else begin
            m_wb = m_mem; m_wb_rd = m_mem_rd;
            m_mem = m_ex; m_mem_rd = m_ex_rd;
            if (st || !in.vld) begin
                m_ex = '0; m_ex_rd = 0; m_ex_rs1 = 0; m_ex_rs2 = 0;
            end else begin
                m_ex = d; m_ex_rd = in.rd; m_ex_rs1 = in.rs1; m_ex_rs2 = in.rs2;
            end
        end
        exp_regs = 32'({m_ex.aop, m_ex.as, m_mem.mr, m_mem.mw, m_wb.m2r, m_wb.rw,
                        m_ex_rd, m_mem_rd, m_wb_rd});
        sb_q.push_back(exp_regs);
        @(posedge clk_i);
        #1;
        check_val("pipe_regs", 32'({ex_ALUOp_o, ex_ALUSrc_o, mem_MemRead_o, mem_MemWrite_o,
                                    wb_MemtoReg_o, wb_RegWrite_o, ex_rd_o, mem_rd_o, wb_rd_o}),
                  sb_q.pop_front());
        @(negedge clk_i);
    endtask

    // Run prog[]: hold the ID instruction while stalled, drop the one behind a taken branch
    task automatic run_prog(output int stalls, output int flushes);
        int     pc = 0;
        int     budget = prog.size() * 4 + 8;
        bit     squash = 1'b0;
        logic   st, fl;
        instr_t bub;
        bub = mk(7'd0, 0, 0, 0);
        bub.vld = 1'b0;
        stalls = 0; flushes = 0;
        while (pc < prog.size() || squash) begin
            if (budget == 0) begin
                check_val("cycle_budget", 32'(pc), 32'(prog.size()));
                break;
            end
            budget--;
            if (squash) begin
                do_cycle(bub, st, fl);
                squash = 1'b0;
            end else begin
                do_cycle(prog[pc], st, fl);
                if (!st) begin
                    pc++;
                    if (fl) begin
                        squash = 1'b1;
                        pc++;
                    end
                end
            end
            stalls  += int'(st);
            flushes += int'(fl);
        end
        prog.delete();
    endtask

    initial begin
        int     st_n, fl_n;
        instr_t t;
        logic [6:0] ops[7];
        ops = '{T_R, T_I, T_LD, T_ST, T_BR, 7'h7F, 7'h00};
        rst_i = 1'b1; valid_i = 1'b0; Op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        branch_taken_i = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_ex_rd = 0; m_ex_rs1 = 0; m_ex_rs2 = 0; m_mem_rd = 0; m_wb_rd = 0;
        obs_fwd_mem = 0; obs_fwd_wb = 0;
        @(negedge clk_i);

        // Reset held two cycles with an R-type presented, then released
        t = mk(T_R, 1, 2, 3); t.rst = 1'b1;
        prog.push_back(t); prog.push_back(t);
        prog.push_back(mk(T_R, 1, 2, 3));
        run_prog(st_n, fl_n);
        check_val("rst_release_aluop", 32'(ex_ALUOp_o), 32'(2'b10));

        // Load-use with two consumers of the loaded register
        add_nops(3);
        prog.push_back(mk(T_LD, 5, 2, 0));
        prog.push_back(mk(T_R, 6, 5, 1));
        prog.push_back(mk(T_R, 7, 5, 5));
        add_nops(3);
        run_prog(st_n, fl_n);
        check_val("load_use_stalls", 32'(st_n), 32'(EXP_LU_STALLS));

        // Taken branches: one hazard-free, one behind a load (stall wins first)
        add_nops(3);
        prog.push_back(mk(T_BR, 0, 1, 2, 1'b1));
        prog.push_back(mk(T_R, 9, 1, 1));
        prog.push_back(mk(7'd0, 0, 0, 0));
        prog.push_back(mk(T_LD, 8, 2, 0));
        prog.push_back(mk(T_BR, 0, 8, 0, 1'b1));
        prog.push_back(mk(T_R, 10, 1, 1));
        add_nops(3);
        run_prog(st_n, fl_n);
        check_val("branch_flushes", 32'(fl_n), 32'd2);
        check_val("branch_stalls", 32'(st_n), 32'(EXP_LU_STALLS));

        // ALU RAW back-to-back and with one instruction between
        obs_fwd_mem = 0; obs_fwd_wb = 0;
        add_nops(3);
        prog.push_back(mk(T_R, 3, 1, 2));
        prog.push_back(mk(T_R, 4, 3, 3));
        add_nops(3);
        prog.push_back(mk(T_R, 3, 1, 2));
        add_nops(1);
        prog.push_back(mk(T_R, 4, 3, 3));
        add_nops(3);
        run_prog(st_n, fl_n);
        check_val("raw_stalls", 32'(st_n), 32'(EXP_RAW_STALLS));
        check_val("fwd_mem_cycles", 32'(obs_fwd_mem), 32'(EXP_FWD_MEM));
        check_val("fwd_wb_cycles", 32'(obs_fwd_wb), 32'(EXP_FWD_WB));

        // x0 destinations and an illegal opcode never hazard or forward
        obs_fwd_mem = 0; obs_fwd_wb = 0;
        add_nops(3);
        prog.push_back(mk(T_R, 0, 1, 2));
        prog.push_back(mk(T_R, 4, 0, 0));
        prog.push_back(mk(7'h7F, 9, 1, 2));
        prog.push_back(mk(T_R, 10, 9, 9));
        prog.push_back(mk(T_LD, 0, 1, 0));
        prog.push_back(mk(T_R, 11, 0, 0));
        add_nops(3);
        run_prog(st_n, fl_n);
        check_val("x0_stalls", 32'(st_n), 32'd0);
        check_val("x0_fwd_cycles", 32'(obs_fwd_mem + obs_fwd_wb), 32'd0);

        // Reset asserted in what would be a load-use stall cycle
        add_nops(3);
        prog.push_back(mk(T_LD, 5, 2, 0));
        t = mk(T_R, 6, 5, 1); t.rst = 1'b1;
        prog.push_back(t);
        prog.push_back(mk(T_R, 6, 5, 1));
        add_nops(3);
        run_prog(st_n, fl_n);
        check_val("rst_mid_stall_stalls", 32'(st_n), 32'd0);

        // Random instruction mix over a small register set
        for (int i = 0; i < 60; i++) begin
            t = mk(ops[$urandom_range(0, 6)], int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            t.vld = ($urandom_range(0, 7) != 0);
            prog.push_back(t);
        end
        add_nops(3);
        run_prog(st_n, fl_n);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined successor to the single-cycle control decoder. It decodes the ID-stage opcode into the standard control bundle (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble), flushes IF/ID on a taken branch, and optionally computes operand forwarding selects. It sits beside the datapath pipeline registers in the 5-stage CPU top.

## Interface
Parameters:
- OP_W, 7, opcode width
- RA_W, 5, register address width
- ALUOP_W, 2, ALUOp width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  IF/ID holds a valid instruction
- Op_i  in  OP_W  ID-stage opcode
- rs1_i, rs2_i, rd_i  in  RA_W each  ID-stage register fields
- branch_taken_i  in  1  ID-stage branch comparator result
- ex_ALUOp_o  out  ALUOP_W  EX-stage ALU operation class
- ex_ALUSrc_o  out  1  EX-stage ALU operand-B source select
- mem_MemRead_o, mem_MemWrite_o  out  1 each  MEM-stage memory controls
- wb_MemtoReg_o, wb_RegWrite_o  out  1 each  WB-stage writeback controls
- ex_rd_o, mem_rd_o, wb_rd_o  out  RA_W each  destination register per stage
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  zero IF/ID at next edge
- fwd_a_o, fwd_b_o  out  2 each  forwarding selects (see Configuration)

## Operation
- Decode by opcode; any unlisted opcode decodes to all-zero (NOP):
  - 0110011 R: RegWrite=1, ALUOp=10
  - 0010011 I: RegWrite=1, ALUSrc=1, ALUOp=11
  - 0000011 load: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=1, ALUOp=00
  - 0100011 store: ALUSrc=1, MemWrite=1, ALUOp=00
  - 1100011 branch: Branch=1, ALUOp=01
- Operand use:
  - uses_rs1 = 1 for all five listed opcodes.
  - uses_rs2 = 1 for R, store and branch only.
- Load-use hazard:
  - Condition: EX-stage MemRead=1, ex_rd≠0, and ex_rd matches an rs field that the instruction uses.
  - Response: stall_o=1, and a bubble (all-zero control, rd=0) enters ID/EX.
- Bubble is also injected when valid_i=0.
- flush_o = decoded Branch & branch_taken_i & valid_i & ~stall_o.
- Stalled branch: flush_o=0, and the branch is re-evaluated next cycle.
- The branch itself is never squashed; only the IF/ID instruction behind it is.
- Register x0 never creates a hazard or a forward.

## Timing
- Decode, stall_o, flush_o and fwd_* are combinational from current inputs and pipeline state (same cycle).
- Control latency:
  - ex_* valid 1 cycle after ID.
  - mem_* valid 2 cycles after ID.
  - wb_* valid 3 cycles after ID.
- Reset: every pipeline register and every registered output clears to 0 at the next edge while rst_i=1.
- Combinational outputs during reset see zeroed state, so stall_o=0, flush_o=0 and fwd_*=00.
- Reset mid-stall: the stall is dropped and the pipeline is empty after the edge.
- Back-to-back load-use (two consumers of the same load): exactly one stall cycle.
- Stall and flush conditions both present: stall wins.

## Configuration
- Macro PIPE_CTRL_FWD_EN.
- Defined (forwarding compiled in):
  - fwd_x = 10 when mem RegWrite & mem_rd≠0 & mem_rd==ID/EX rsX.
  - Otherwise fwd_x = 01 when wb RegWrite & wb_rd≠0 & wb_rd==ID/EX rsX.
  - Otherwise fwd_x = 00.
  - MEM priority over WB.
  - ID/EX additionally registers rs1/rs2 for this comparison.
  - Stall covers load-use only.
- Undefined:
  - fwd_a_o = fwd_b_o = 00.
  - Stall on any used rs matching a RegWrite destination (≠0) in EX or MEM.
  - WB-stage conflicts are resolved by the write-first register file.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp encodings
  - forwarding select constants
  - ctrl_t bundle typedef
- Sub-module ctrl_decode: combinational opcode → ctrl_t plus uses_rs1/uses_rs2.
- pipe_ctrl_unit instantiates ctrl_decode and contains the pipeline registers, the hazard logic and the forwarding logic.

## Test plan
- Reset: hold rst_i 2 cycles with an R-type on Op_i → all outputs 0; one cycle after release, ex_ALUOp_o=10.
- Load x5 followed by add x6,x5,x1 → stall_o=1 for exactly one cycle; ex_* all 0 in the bubble cycle; add reaches EX one cycle later.
- Taken beq in ID (branch_taken_i=1), no hazard → flush_o=1 that cycle only; the beq's control reaches EX (ex_ALUOp_o=01).
- With PIPE_CTRL_FWD_EN: add x3 then sub x4,x3,x3 → fwd_a_o=fwd_b_o=10 when sub is in EX. One instruction gap between them → 01.
- Without PIPE_CTRL_FWD_EN: same sequence → two stall cycles; fwd_* stay 00.
- Opcode 1111111 and any dest targeting x0 → NOP control, with no stall or forward from x0.
